// File: rtl/bcd_result_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_result_encoder_if
// Brief    : Request/result bundle between the arithmetic stage and the
//            binary-to-BCD result encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_result_encoder_if;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        neg;

    // Requester side: issues conversions and reads results.
    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  neg
    );

    // Encoder side.
    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output neg
    );
endinterface
`default_nettype wire

// File: rtl/bcd_result_encoder.sv
`default_nettype none
// ============================================================================
// Module   : bcd_result_encoder
// Brief    : Iterative shift-add-3 converter, 8-bit binary to three packed BCD
//            digits, with start/busy/done handshake. Define
//            BCD_RESULT_SIGNED_EN for two's-complement input with sign output.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_result_encoder (
    input  wire                 clk,
    input  wire                 rst,
    bcd_result_encoder_if.slave io_bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam int         C_NUM_DIGITS = 3;
    localparam logic [2:0] C_LAST_SHIFT = 3'd7;

    logic [0:0]  r_state;
    logic [7:0]  r_shift;
    logic [11:0] r_acc;
    logic [2:0]  r_cnt;
    logic [11:0] r_bcd;
    logic        r_busy;
    logic        r_done;

    logic        w_start;
    logic [7:0]  w_bin;
    logic [7:0]  w_mag;
    logic [11:0] w_adj;
    logic [19:0] w_work;
    logic [19:0] w_shifted;

    assign w_start = io_bus.start;
    assign w_bin   = io_bus.bin;

`ifdef BCD_RESULT_SIGNED_EN
    logic r_sign;
    logic r_neg;

    // -128 negates to 8'h80, which is still read correctly as magnitude 128.
    assign w_mag = w_bin[7] ? (8'd0 - w_bin) : w_bin;
`else
    assign w_mag = w_bin;
`endif

    // Every digit is adjusted, including hundreds, even though it stays <= 2.
    generate
        for (genvar d = 0; d < C_NUM_DIGITS; d++) begin : g_digit
            assign w_adj[4*d +: 4] = (r_acc[4*d +: 4] >= 4'd5) ?
                                     (r_acc[4*d +: 4] + 4'd3) :
                                      r_acc[4*d +: 4];
        end
    endgenerate

    assign w_work    = {w_adj, r_shift};
    assign w_shifted = w_work << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= 8'd0;
            r_acc   <= 12'd0;
            r_cnt   <= 3'd0;
            r_bcd   <= 12'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_shift <= w_mag;
                        r_acc   <= 12'd0;
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc   <= w_shifted[19:8];
                    r_shift <= w_shifted[7:0];
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == C_LAST_SHIFT) begin
                        r_bcd   <= w_shifted[19:8];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BCD_RESULT_SIGNED_EN
    // Sign is captured at acceptance and only published on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_start) begin
                r_sign <= w_bin[7];
            end
            if (r_state == S_SHIFT && r_cnt == C_LAST_SHIFT) begin
                r_neg <= r_sign;
            end
        end
    end

    assign io_bus.neg = r_neg;
`else
    assign io_bus.neg = 1'b0;
`endif

    assign io_bus.busy = r_busy;
    assign io_bus.done = r_done;
    assign io_bus.bcd  = r_bcd;

endmodule
`default_nettype wire
